// File: rtl/sys_array_nxn_if.sv
// Operand/result handshake bundle for the N x N systolic matrix multiplier.
// The master side drives jobs and operands; the slave side is the array.
interface sys_array_nxn_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32,
  parameter int unsigned KW = 8
);
  localparam int unsigned IW = $clog2(N * N);

  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            res_valid;
  logic            res_ready;
  logic [AW-1:0]   res_data;
  logic [IW-1:0]   res_idx;
  logic            res_last;
  logic            busy;

  modport master (
    output start, k_len, in_valid, a_col, b_row, res_ready,
    input  in_ready, res_valid, res_data, res_idx, res_last, busy
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, res_ready,
    output in_ready, res_valid, res_data, res_idx, res_last, busy
  );
endinterface

// File: rtl/sys_array_nxn.sv
// Output-stationary N x N systolic multiplier: C = A x B with runtime K, input skewing,
// a zero-fed drain phase and row-major serial readout of the accumulators.
module sys_array_nxn #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 32,
  parameter int unsigned KW = 8
) (
  input  logic           clk,
  input  logic           reset,
  sys_array_nxn_if.slave bus
);
  localparam int unsigned     IW        = $clog2(N * N);
  localparam int unsigned     DNW       = $clog2(2 * N);
  localparam logic [IW-1:0]   IdxLast   = IW'(N * N - 1);
  localparam logic [DNW-1:0]  DrainLast = DNW'(2 * N - 2);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StOut} state_e;

  state_e         st_q, st_d;
  logic [KW-1:0]  k_q, k_d, cnt_q, cnt_d;
  logic [DNW-1:0] drn_q, drn_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           in_ready_q, in_ready_d, res_valid_q, res_valid_d, busy_q, busy_d;

  // Row i of A uses skew stages 0..i-1 of a_sk; column j of B likewise in b_sk.
  logic signed [DW-1:0] a_sk_q [N][N];
  logic signed [DW-1:0] a_sk_d [N][N];
  logic signed [DW-1:0] b_sk_q [N][N];
  logic signed [DW-1:0] b_sk_d [N][N];
  logic signed [DW-1:0] a_pe_q [N*N];
  logic signed [DW-1:0] a_pe_d [N*N];
  logic signed [DW-1:0] b_pe_q [N*N];
  logic signed [DW-1:0] b_pe_d [N*N];
  logic signed [AW-1:0] acc_q  [N*N];
  logic signed [AW-1:0] acc_d  [N*N];

  logic signed [DW-1:0] a_src [N];
  logic signed [DW-1:0] b_src [N];
  logic signed [DW-1:0] a_edge [N];
  logic signed [DW-1:0] b_edge [N];
  logic signed [DW-1:0] a_in [N*N];
  logic signed [DW-1:0] b_in [N*N];
  logic                 en;

  assign en = ((st_q == StLoad) && bus.in_valid && in_ready_q) || (st_q == StDrain);

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_src[i] = (st_q == StDrain) ? '0 : bus.a_col[i*DW +: DW];
    assign b_src[i] = (st_q == StDrain) ? '0 : bus.b_row[i*DW +: DW];
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src[i];
      assign b_edge[i] = b_src[i];
    end else begin : g_skew
      assign a_edge[i] = a_sk_q[i][i-1];
      assign b_edge[i] = b_sk_q[i][i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in[i*N+j] = a_edge[i];
      end else begin : g_a_pe
        assign a_in[i*N+j] = a_pe_q[i*N+j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in[i*N+j] = b_edge[j];
      end else begin : g_b_pe
        assign b_in[i*N+j] = b_pe_q[(i-1)*N+j];
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    a_sk_d      = a_sk_q;
    b_sk_d      = b_sk_q;
    a_pe_d      = a_pe_q;
    b_pe_d      = b_pe_q;
    acc_d       = acc_q;

    if (en) begin
      for (int i = 0; i < N; i++) begin
        a_sk_d[i][0] = a_src[i];
        b_sk_d[i][0] = b_src[i];
        for (int s = 1; s < N; s++) begin
          a_sk_d[i][s] = a_sk_q[i][s-1];
          b_sk_d[i][s] = b_sk_q[i][s-1];
        end
      end
      // Sign-extend operands to AW first so the product wraps modulo 2^AW.
      for (int p = 0; p < N * N; p++) begin
        a_pe_d[p] = a_in[p];
        b_pe_d[p] = b_in[p];
        acc_d[p]  = acc_q[p] + AW'(a_in[p]) * AW'(b_in[p]);
      end
    end

    unique case (st_q)
      StIdle: begin
        if (bus.start) begin
          for (int i = 0; i < N; i++) begin
            for (int s = 0; s < N; s++) begin
              a_sk_d[i][s] = '0;
              b_sk_d[i][s] = '0;
            end
          end
          for (int p = 0; p < N * N; p++) begin
            a_pe_d[p] = '0;
            b_pe_d[p] = '0;
            acc_d[p]  = '0;
          end
          k_d    = bus.k_len;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (bus.k_len != '0) begin
            st_d       = StLoad;
            in_ready_d = 1'b1;
          end else begin
            st_d        = StOut;
            res_valid_d = 1'b1;
            idx_d       = '0;
          end
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == k_q - 1'b1) begin
            st_d       = StDrain;
            in_ready_d = 1'b0;
            drn_d      = '0;
          end
        end
      end
      StDrain: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DrainLast) begin
          st_d        = StOut;
          res_valid_d = 1'b1;
          idx_d       = '0;
        end
      end
      StOut: begin
        if (bus.res_ready) begin
          if (idx_q == IdxLast) begin
            st_d        = StIdle;
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= StIdle;
      k_q         <= '0;
      cnt_q       <= '0;
      drn_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N; s++) begin
          a_sk_q[i][s] <= '0;
          b_sk_q[i][s] <= '0;
        end
      end
      for (int p = 0; p < N * N; p++) begin
        a_pe_q[p] <= '0;
        b_pe_q[p] <= '0;
        acc_q[p]  <= '0;
      end
    end else begin
      st_q        <= st_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      a_sk_q      <= a_sk_d;
      b_sk_q      <= b_sk_d;
      a_pe_q      <= a_pe_d;
      b_pe_q      <= b_pe_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.res_idx   = idx_q;
  assign bus.res_last  = res_valid_q && (idx_q == IdxLast);
  assign bus.res_data  = res_valid_q ? acc_q[idx_q] : '0;
endmodule

// File: tb/tb_sys_array_nxn.sv
// Directed bench for sys_array_nxn (N=3): identity/gap/back-pressure/overflow/K=0/reset cases
// with hand-computed result matrices.
module tb_sys_array_nxn;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned KW = 8;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     cyc = 0, errors = 0, checks = 0, t_start = 0, t_valid = 0;
  int     am [N][4];
  int     bm [4][N];
  longint exp_c [N*N];

  sys_array_nxn_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();

  sys_array_nxn #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        am[i][k] = 0;
        bm[k][i] = 0;
      end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_job(input int k);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    t_start   = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed(input string name, input int k, input bit gaps, input bit poke_start);
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < N; i++) begin
        bus.a_col[i*DW +: DW] = DW'(am[i][t]);
        bus.b_row[i*DW +: DW] = DW'(bm[t][i]);
      end
      bus.in_valid = 1'b1;
      check({name, "_in_ready"}, bus.in_ready, 1);
      @(negedge clk);
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.a_col    = '1;
        bus.b_row    = '1;
        bus.start    = poke_start;
        bus.k_len    = '0;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input bit slow, input bit poke_start);
    int w = 0, ph = 0, guard = 0;
    while (!bus.res_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    t_valid = cyc;
    if (!bus.res_valid) begin
      check({name, "_timeout"}, 0, 1);
      return;
    end
    guard = 0;
    while (w < N * N && guard < 200) begin
      bus.res_ready = slow ? (ph == 2) : 1'b1;
      bus.start     = poke_start;
      bus.k_len     = '0;
      check({name, "_valid"}, bus.res_valid, 1);
      check({name, "_idx"}, bus.res_idx, w);
      check({name, "_data"}, $signed(bus.res_data), exp_c[w]);
      if (bus.res_ready) begin
        check({name, "_last"}, bus.res_last, (w == N * N - 1) ? 1 : 0);
        w++;
      end
      ph = (ph == 2) ? 0 : ph + 1;
      @(negedge clk);
      guard++;
    end
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    check({name, "_count"}, w, N * N);
    check({name, "_valid_end"}, bus.res_valid, 0);
    check({name, "_busy_end"}, bus.busy, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_in_ready"}, bus.in_ready, 0);
    check({name, "_res_valid"}, bus.res_valid, 0);
    check({name, "_res_last"}, bus.res_last, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_res_data"}, bus.res_data, 0);
    check({name, "_res_idx"}, bus.res_idx, 0);
  endtask

  task automatic load_ident_b19();
    clear_mats();
    for (int i = 0; i < N; i++) am[i][i] = 1;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) bm[k][j] = k * N + j + 1;
    for (int p = 0; p < N * N; p++) exp_c[p] = p + 1;
  endtask

  initial begin
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_col = '0;   bus.b_row = '0; bus.res_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero_outputs("rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Identity A times B = 1..9; first res_valid 9 cycles after start.
    load_ident_b19();
    start_job(3);
    feed("t1", 3, 1'b0, 1'b0);
    collect("t1", 1'b0, 1'b0);
    check("t1_latency", t_valid - t_start, 9);

    // All-2 A, all -3 B, K=4, gapped beats, stray start in LOAD/DRAIN: every C = -24.
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        am[i][k] = 2;
        bm[k][i] = -3;
      end
    for (int p = 0; p < N * N; p++) exp_c[p] = -24;
    start_job(4);
    feed("t2", 4, 1'b1, 1'b1);
    collect("t2", 1'b0, 1'b0);

    // res_ready 0,0,1 back-pressure with start held high throughout OUT.
    load_ident_b19();
    start_job(3);
    feed("t3", 3, 1'b0, 1'b0);
    collect("t3", 1'b1, 1'b1);
    @(negedge clk);
    check("t3_stay_idle_busy", bus.busy, 0);
    check("t3_stay_idle_valid", bus.res_valid, 0);

    // Accumulator wrap: 2 * (-32768)^2 = 2^31 -> -2^31.
    clear_mats();
    am[0][0] = -32768; am[0][1] = -32768;
    bm[0][0] = -32768; bm[1][0] = -32768;
    for (int p = 0; p < N * N; p++) exp_c[p] = 0;
    exp_c[0] = -64'sd2147483648;
    start_job(2);
    feed("t4", 2, 1'b0, 1'b0);
    collect("t4", 1'b0, 1'b0);

    // K=0: straight to OUT, nine zero words.
    for (int p = 0; p < N * N; p++) exp_c[p] = 0;
    start_job(0);
    check("t5_in_ready", bus.in_ready, 0);
    collect("t5", 1'b0, 1'b0);
    check("t5_latency", t_valid - t_start, 1);

    // Async reset after 2 of 3 beats, then a clean identity job.
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        am[i][k] = 100;
        bm[k][i] = 50;
      end
    start_job(3);
    feed("t6a", 2, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_zero_outputs("t6_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mats();
    for (int i = 0; i < N; i++) am[i][i] = 1;
    bm[0][0] = 2; bm[0][1] = -1; bm[0][2] = 5;
    bm[1][0] = 0; bm[1][1] = 7;  bm[1][2] = -3;
    bm[2][0] = 4; bm[2][1] = 4;  bm[2][2] = 1;
    exp_c[0] = 2; exp_c[1] = -1; exp_c[2] = 5;
    exp_c[3] = 0; exp_c[4] = 7;  exp_c[5] = -3;
    exp_c[6] = 4; exp_c[7] = 4;  exp_c[8] = 1;
    start_job(3);
    feed("t6", 3, 1'b0, 1'b0);
    collect("t6", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
